// File: rtl/ma_sample_feeder.sv
// ma_sample_feeder: paced sample source for the moving-average filter input.
// Samples arrive on a valid/ready stream into a small FIFO. One sample is
// released per pacing slot as a single-cycle data_refresh strobe, and
// feed_data holds that sample until the next strobe.
module ma_sample_feeder #(
  parameter int DATA_WIDTH     = 16,
  parameter int FIFO_DEPTH     = 8,
  parameter int INTERVAL_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic signed [DATA_WIDTH-1:0]     s_data,
  input  logic        [INTERVAL_WIDTH-1:0] interval,
  input  logic                             clr_status,
  output logic                             data_refresh,
  output logic signed [DATA_WIDTH-1:0]     feed_data,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic                             underrun,
  output logic [15:0]                      feed_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  // Sample storage; left unreset so it can map onto RAM primitives.
  logic signed [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [AW-1:0]                wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]                rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0]                level_reg, level_next;
  logic [INTERVAL_WIDTH-1:0]    cnt_reg, cnt_next;
  logic                         refresh_reg, refresh_next;
  logic signed [DATA_WIDTH-1:0] feed_data_reg, feed_data_next;
  logic                         underrun_reg, underrun_next;
  logic [15:0]                  feed_count_reg, feed_count_next;

  logic [INTERVAL_WIDTH-1:0]    eff_m1;
  logic                         slot;
  logic                         push;
  logic                         pop;

  // Ready comes only from the registered level, so a pop in the same cycle
  // never opens room for a push into a full FIFO.
  assign s_ready = (level_reg != FULL_LEVEL);
  assign push    = s_valid && s_ready;

  // An interval of 0 behaves like 1 (slot every enabled cycle). The >=
  // compare makes a shrinking interval produce a slot instead of letting the
  // counter run past the reload point.
  assign eff_m1 = (interval == '0) ? '0 : interval - INTERVAL_WIDTH'(1);
  assign slot   = enable && (cnt_reg >= eff_m1);
  assign pop    = slot && (level_reg != '0);

  // Next-state logic for pacing, FIFO bookkeeping, strobe and status.
  always_comb begin
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    level_next      = level_reg;
    cnt_next        = cnt_reg;
    refresh_next    = pop;
    feed_data_next  = feed_data_reg;
    underrun_next   = underrun_reg;
    feed_count_next = feed_count_reg;

    if (enable) begin
      cnt_next = slot ? '0 : cnt_reg + INTERVAL_WIDTH'(1);
    end

    if (push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end

    if (pop) begin
      rd_ptr_next     = rd_ptr_reg + AW'(1);
      feed_data_next  = mem[rd_ptr_reg];
      feed_count_next = feed_count_reg + 16'd1;
    end

    case ({push, pop})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase

    // A fresh underrun takes priority over a clear in the same cycle.
    if (slot && (level_reg == '0)) begin
      underrun_next = 1'b1;
    end else if (clr_status) begin
      underrun_next = 1'b0;
    end
  end

  // FIFO write port.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= s_data;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      cnt_reg        <= '0;
      refresh_reg    <= 1'b0;
      feed_data_reg  <= '0;
      underrun_reg   <= 1'b0;
      feed_count_reg <= '0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      level_reg      <= level_next;
      cnt_reg        <= cnt_next;
      refresh_reg    <= refresh_next;
      feed_data_reg  <= feed_data_next;
      underrun_reg   <= underrun_next;
      feed_count_reg <= feed_count_next;
    end
  end

  assign data_refresh = refresh_reg;
  assign feed_data    = feed_data_reg;
  assign fifo_level   = level_reg;
  assign underrun     = underrun_reg;
  assign feed_count   = feed_count_reg;

endmodule
